// File: rtl/pc_trap_sequencer_if.sv
// pc_trap_sequencer_if: groups the core/peripheral facing signals of the
// PC/trap sequencer. The core side (master) drives next-PC, trap requests,
// interrupt lines and mask writes; the sequencer (slave) returns the PC,
// trap status and the interrupt pending/mask registers.
interface pc_trap_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int N_IRQ = 4
);
  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // core -> sequencer
  logic             stall;
  logic [XLEN-1:0]  pc_next_in;
  logic             exc_req;
  logic [3:0]       exc_code;
  logic             eret;
  logic [N_IRQ-1:0] irq;
  logic             irq_ack;
  logic [IDW-1:0]   ack_id;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;

  // sequencer -> core
  logic [XLEN-1:0]  pc;
  logic             kernel;
  logic [XLEN-1:0]  epc;
  logic [7:0]       cause;
  logic [N_IRQ-1:0] irq_pending;
  logic [N_IRQ-1:0] irq_mask;
  logic             trap_taken;

  modport master (
    output stall, pc_next_in, exc_req, exc_code, eret, irq,
           irq_ack, ack_id, mask_we, mask_wdata,
    input  pc, kernel, epc, cause, irq_pending, irq_mask, trap_taken
  );

  modport slave (
    input  stall, pc_next_in, exc_req, exc_code, eret, irq,
           irq_ack, ack_id, mask_we, mask_wdata,
    output pc, kernel, epc, cause, irq_pending, irq_mask, trap_taken
  );
endinterface

// File: rtl/pc_trap_sequencer.sv
// pc_trap_sequencer: program counter register plus trap entry/return logic.
// Selects the next PC from the core next-PC, exceptions, kernel-space
// violations, illegal eret, maskable edge-captured interrupts and eret.
// Kernel mode is pc[XLEN-1] = 1; traps are only taken from user mode.
// Build option: define VECTORED_IRQ_EN to give each interrupt line its own
// vector (VEC_BASE + 16 + 4*k); otherwise all interrupts use VEC_BASE + 4.
module pc_trap_sequencer #(
  parameter int              XLEN     = 32,
  parameter int              N_IRQ    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] VEC_BASE = {1'b1, {(XLEN-1){1'b0}}}
) (
  input logic                clk,
  input logic                reset,
  pc_trap_sequencer_if.slave bus
);

  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // Which source drives the PC this cycle, in priority order.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_EXC,
    SEL_KVIOL,
    SEL_BAD_ERET,
    SEL_IRQ,
    SEL_ERET,
    SEL_SEQ
  } sel_e;

  // architectural state
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  epc_r;
  logic [7:0]       cause_r;
  logic [N_IRQ-1:0] pending_r;
  logic [N_IRQ-1:0] mask_r;
  logic [N_IRQ-1:0] irq_prev_r;
  logic             trap_taken_r;

  // combinational next values
  logic [XLEN-1:0]  pc_next_s;
  logic [XLEN-1:0]  epc_next_s;
  logic [7:0]       cause_next_s;
  logic [N_IRQ-1:0] pending_next_s;
  logic [N_IRQ-1:0] mask_next_s;
  logic             trap_next_s;

  // decode helpers
  logic             user_s;
  logic [N_IRQ-1:0] rise_s;
  logic [N_IRQ-1:0] ack_hit_s;
  logic [N_IRQ-1:0] enabled_s;
  logic [IDW-1:0]   irq_idx_s;
  logic             irq_hit_s;
  logic [6:0]       irq_code_s;
  logic [XLEN-1:0]  exc_vec_s;
  logic [XLEN-1:0]  irq_vec_s;
  sel_e             sel_s;

  assign user_s     = ~pc_r[XLEN-1];
  assign rise_s     = bus.irq & ~irq_prev_r;
  assign enabled_s  = pending_r & mask_r;
  assign irq_code_s = 7'(irq_idx_s);
  assign exc_vec_s  = VEC_BASE + XLEN'(32'd8);

`ifdef VECTORED_IRQ_EN
  assign irq_vec_s = VEC_BASE + XLEN'(32'd16) + (XLEN'(irq_idx_s) << 2'd2);
`else
  assign irq_vec_s = VEC_BASE + XLEN'(32'd4);
`endif

  // Decode the acknowledge into a one-hot clear; out-of-range ids match nothing.
  always_comb begin
    ack_hit_s = {N_IRQ{1'b0}};
    for (int i = 0; i < N_IRQ; i++) begin
      ack_hit_s[i] = bus.irq_ack & (bus.ack_id == IDW'(i));
    end
  end

  // Pending update: a new rising edge beats a same-cycle acknowledge.
  always_comb begin
    pending_next_s = (pending_r & ~ack_hit_s) | rise_s;
  end

  // Mask register load; the new mask is seen by trap decisions a cycle later.
  always_comb begin
    if (bus.mask_we) begin
      mask_next_s = bus.mask_wdata;
    end else begin
      mask_next_s = mask_r;
    end
  end

  // Priority encoder: lowest enabled pending index wins.
  always_comb begin
    irq_idx_s = {IDW{1'b0}};
    irq_hit_s = |enabled_s;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      irq_idx_s = enabled_s[i] ? IDW'(i) : irq_idx_s;
    end
  end

  // Choose the PC source; traps only from user mode, nothing moves on stall.
  always_comb begin
    sel_s = SEL_SEQ;
    if (bus.stall) begin
      sel_s = SEL_HOLD;
    end else if (user_s && bus.exc_req) begin
      sel_s = SEL_EXC;
    end else if (user_s && bus.pc_next_in[XLEN-1] && !bus.eret) begin
      sel_s = SEL_KVIOL;
    end else if (user_s && bus.eret) begin
      sel_s = SEL_BAD_ERET;
    end else if (user_s && irq_hit_s) begin
      sel_s = SEL_IRQ;
    end else if (!user_s && bus.eret) begin
      sel_s = SEL_ERET;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Compute next PC/EPC/cause and the trap pulse for the selected source.
  always_comb begin
    pc_next_s    = pc_r;
    epc_next_s   = epc_r;
    cause_next_s = cause_r;
    trap_next_s  = 1'b0;
    case (sel_s)
      SEL_HOLD: begin
        pc_next_s = pc_r;
      end
      SEL_EXC: begin
        pc_next_s    = exc_vec_s;
        epc_next_s   = pc_r;
        cause_next_s = {4'b0000, bus.exc_code};
        trap_next_s  = 1'b1;
      end
      SEL_KVIOL: begin
        pc_next_s    = exc_vec_s;
        epc_next_s   = pc_r;
        cause_next_s = 8'h7F;
        trap_next_s  = 1'b1;
      end
      SEL_BAD_ERET: begin
        pc_next_s    = exc_vec_s;
        epc_next_s   = pc_r;
        cause_next_s = 8'h7E;
        trap_next_s  = 1'b1;
      end
      SEL_IRQ: begin
        // Resume at the instruction that would have run; the pending bit
        // stays set until the handler acknowledges it.
        pc_next_s    = irq_vec_s;
        epc_next_s   = bus.pc_next_in;
        cause_next_s = {1'b1, irq_code_s};
        trap_next_s  = 1'b1;
      end
      SEL_ERET: begin
        pc_next_s = epc_r;
      end
      SEL_SEQ: begin
        pc_next_s = bus.pc_next_in;
      end
      default: begin
        pc_next_s = pc_r;
      end
    endcase
  end

  // State register: synchronous reset, edge capture runs even while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      epc_r        <= {XLEN{1'b0}};
      cause_r      <= 8'h00;
      pending_r    <= {N_IRQ{1'b0}};
      mask_r       <= {N_IRQ{1'b1}};
      irq_prev_r   <= {N_IRQ{1'b0}};
      trap_taken_r <= 1'b0;
    end else begin
      pc_r         <= pc_next_s;
      epc_r        <= epc_next_s;
      cause_r      <= cause_next_s;
      pending_r    <= pending_next_s;
      mask_r       <= mask_next_s;
      irq_prev_r   <= bus.irq;
      trap_taken_r <= trap_next_s;
    end
  end

  assign bus.pc          = pc_r;
  assign bus.kernel      = pc_r[XLEN-1];
  assign bus.epc         = epc_r;
  assign bus.cause       = cause_r;
  assign bus.irq_pending = pending_r;
  assign bus.irq_mask    = mask_r;
  assign bus.trap_taken  = trap_taken_r;

endmodule

// File: tb/tb_pc_trap_sequencer.sv
// tb_pc_trap_sequencer: directed scenarios with hand-computed expectations
// for the PC/trap sequencer (default parameters, XLEN=32, N_IRQ=4).
module tb_pc_trap_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_trap_sequencer_if #(.XLEN(32), .N_IRQ(4)) bus ();

  pc_trap_sequencer #(
    .XLEN(32), .N_IRQ(4), .RESET_PC(32'h0), .VEC_BASE(32'h8000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected interrupt vector for line k.
  function automatic logic [31:0] irq_vec(input int k);
`ifdef VECTORED_IRQ_EN
    return 32'h8000_0010 + 32'(4 * k);
`else
    return 32'h8000_0004 + 32'(0 * k);
`endif
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0; bus.pc_next_in = 32'h40; bus.exc_req = 1'b0; bus.exc_code = 4'h0;
    bus.eret = 1'b0; bus.irq = 4'h0; bus.irq_ack = 1'b0; bus.ack_id = 2'd0;
    bus.mask_we = 1'b0; bus.mask_wdata = 4'h0;
    tick(); tick();
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h exp %h", bus.pc, 32'h0); end
    total++; if (bus.epc !== 32'h0) begin bad++; $display("FAIL rst_epc: got %h exp %h", bus.epc, 32'h0); end
    total++; if (bus.cause !== 8'h00) begin bad++; $display("FAIL rst_cause: got %h exp %h", bus.cause, 8'h00); end
    total++; if (bus.irq_mask !== 4'hF) begin bad++; $display("FAIL rst_mask: got %h exp %h", bus.irq_mask, 4'hF); end
    total++; if (bus.irq_pending !== 4'h0) begin bad++; $display("FAIL rst_pending: got %h exp %h", bus.irq_pending, 4'h0); end
    total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL rst_trap: got %b exp 0", bus.trap_taken); end
    total++; if (bus.kernel !== 1'b0) begin bad++; $display("FAIL rst_kernel: got %b exp 0", bus.kernel); end
    reset = 1'b0;
    tick();
    total++; if (bus.pc !== 32'h40) begin bad++; $display("FAIL rst_release_pc: got %h exp %h", bus.pc, 32'h40); end
  endtask

  task automatic test_irq_basic();
    bus.pc_next_in = 32'h100; bus.irq = 4'b0100;
    tick();
    total++; if (bus.pc !== 32'h100) begin bad++; $display("FAIL irq_pre_pc: got %h exp %h", bus.pc, 32'h100); end
    total++; if (bus.irq_pending !== 4'b0100) begin bad++; $display("FAIL irq_capture: got %b exp %b", bus.irq_pending, 4'b0100); end
    bus.pc_next_in = 32'h104;
    tick();
    total++; if (bus.pc !== irq_vec(2)) begin bad++; $display("FAIL irq_vec_pc: got %h exp %h", bus.pc, irq_vec(2)); end
    total++; if (bus.epc !== 32'h104) begin bad++; $display("FAIL irq_epc: got %h exp %h", bus.epc, 32'h104); end
    total++; if (bus.cause !== 8'h82) begin bad++; $display("FAIL irq_cause: got %h exp %h", bus.cause, 8'h82); end
    total++; if (bus.trap_taken !== 1'b1) begin bad++; $display("FAIL irq_trap_pulse: got %b exp 1", bus.trap_taken); end
    total++; if (bus.kernel !== 1'b1) begin bad++; $display("FAIL irq_kernel: got %b exp 1", bus.kernel); end
    bus.irq = 4'b0000; bus.pc_next_in = 32'h8000_0008;
    tick();
    total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL irq_pulse_end: got %b exp 0", bus.trap_taken); end
    bus.irq = 4'b0100; bus.pc_next_in = 32'h8000_000C;
    tick();
    total++; if (bus.pc !== 32'h8000_000C) begin bad++; $display("FAIL kern_no_reentry_pc: got %h exp %h", bus.pc, 32'h8000_000C); end
    total++; if (bus.cause !== 8'h82 || bus.epc !== 32'h104) begin bad++; $display("FAIL kern_state_kept: cause %h epc %h exp 82 00000104", bus.cause, bus.epc); end
    total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL kern_no_trap: got %b exp 0", bus.trap_taken); end
    bus.irq_ack = 1'b1; bus.ack_id = 2'd2;
    tick();
    bus.irq_ack = 1'b0;
    total++; if (bus.irq_pending !== 4'b0000) begin bad++; $display("FAIL irq_ack2: got %b exp %b", bus.irq_pending, 4'b0000); end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++; if (bus.pc !== 32'h104) begin bad++; $display("FAIL eret_pc: got %h exp %h", bus.pc, 32'h104); end
  endtask

  task automatic test_mask_ack();
    bus.irq = 4'b0000; bus.mask_we = 1'b1; bus.mask_wdata = 4'b0111; bus.pc_next_in = 32'h108;
    tick();
    bus.mask_we = 1'b0;
    total++; if (bus.irq_mask !== 4'b0111) begin bad++; $display("FAIL mask_write: got %b exp %b", bus.irq_mask, 4'b0111); end
    bus.irq = 4'b1010; bus.pc_next_in = 32'h10C;
    tick();
    total++; if (bus.irq_pending !== 4'b1010) begin bad++; $display("FAIL mask_capture: got %b exp %b", bus.irq_pending, 4'b1010); end
    bus.pc_next_in = 32'h110;
    tick();
    total++; if (bus.pc !== irq_vec(1)) begin bad++; $display("FAIL mask_vec_pc: got %h exp %h", bus.pc, irq_vec(1)); end
    total++; if (bus.cause !== 8'h81) begin bad++; $display("FAIL mask_cause: got %h exp %h", bus.cause, 8'h81); end
    total++; if (bus.irq_pending !== 4'b1010) begin bad++; $display("FAIL mask_pending_kept: got %b exp %b", bus.irq_pending, 4'b1010); end
    bus.pc_next_in = 32'h8000_0010; bus.irq_ack = 1'b1; bus.ack_id = 2'd1;
    tick();
    bus.irq_ack = 1'b0;
    total++; if (bus.irq_pending !== 4'b1000) begin bad++; $display("FAIL mask_ack1: got %b exp %b", bus.irq_pending, 4'b1000); end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++; if (bus.pc !== 32'h110) begin bad++; $display("FAIL mask_eret: got %h exp %h", bus.pc, 32'h110); end
    bus.pc_next_in = 32'h114;
    tick();
    total++; if (bus.pc !== 32'h114 || bus.trap_taken !== 1'b0) begin bad++; $display("FAIL mask_blocks: pc %h trap %b exp 00000114 0", bus.pc, bus.trap_taken); end
  endtask

  task automatic test_exception_priority();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'hF; bus.pc_next_in = 32'h200;
    tick();
    bus.mask_we = 1'b0;
    total++; if (bus.pc !== 32'h200 || bus.trap_taken !== 1'b0) begin bad++; $display("FAIL mask_delay: pc %h trap %b exp 00000200 0", bus.pc, bus.trap_taken); end
    bus.exc_req = 1'b1; bus.exc_code = 4'h3; bus.pc_next_in = 32'h204;
    tick();
    bus.exc_req = 1'b0;
    total++; if (bus.pc !== 32'h8000_0008) begin bad++; $display("FAIL exc_pc: got %h exp %h", bus.pc, 32'h8000_0008); end
    total++; if (bus.epc !== 32'h200) begin bad++; $display("FAIL exc_epc: got %h exp %h", bus.epc, 32'h200); end
    total++; if (bus.cause !== 8'h03) begin bad++; $display("FAIL exc_cause: got %h exp %h", bus.cause, 8'h03); end
    total++; if (bus.trap_taken !== 1'b1) begin bad++; $display("FAIL exc_trap: got %b exp 1", bus.trap_taken); end
    bus.irq = 4'b0000; bus.irq_ack = 1'b1; bus.ack_id = 2'd3; bus.eret = 1'b1;
    tick();
    bus.irq_ack = 1'b0; bus.eret = 1'b0;
    total++; if (bus.pc !== 32'h200 || bus.irq_pending !== 4'b0000) begin bad++; $display("FAIL exc_return: pc %h pend %b exp 00000200 0000", bus.pc, bus.irq_pending); end
  endtask

  task automatic test_kernel_violation();
    bus.pc_next_in = 32'h300;
    tick();
    bus.pc_next_in = 32'h8000_0000;
    tick();
    total++; if (bus.pc !== 32'h8000_0008) begin bad++; $display("FAIL kviol_pc: got %h exp %h", bus.pc, 32'h8000_0008); end
    total++; if (bus.cause !== 8'h7F || bus.epc !== 32'h300) begin bad++; $display("FAIL kviol_cause_epc: cause %h epc %h exp 7f 00000300", bus.cause, bus.epc); end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++; if (bus.pc !== 32'h300) begin bad++; $display("FAIL kviol_eret: got %h exp %h", bus.pc, 32'h300); end
  endtask

  task automatic test_illegal_eret();
    bus.pc_next_in = 32'h304; bus.eret = 1'b1;
    tick();
    total++; if (bus.pc !== 32'h8000_0008 || bus.cause !== 8'h7E) begin bad++; $display("FAIL bad_eret: pc %h cause %h exp 80000008 7e", bus.pc, bus.cause); end
    total++; if (bus.epc !== 32'h300 || bus.trap_taken !== 1'b1) begin bad++; $display("FAIL bad_eret_epc: epc %h trap %b exp 00000300 1", bus.epc, bus.trap_taken); end
    tick();
    bus.eret = 1'b0;
    total++; if (bus.pc !== 32'h300) begin bad++; $display("FAIL bad_eret_ret: got %h exp %h", bus.pc, 32'h300); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.irq = 4'b0001; bus.exc_req = 1'b1; bus.exc_code = 4'h5; bus.pc_next_in = 32'h400;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.pc !== 32'h300 || bus.trap_taken !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d]: pc %h trap %b exp 00000300 0", c, bus.pc, bus.trap_taken); end
    end
    total++; if (bus.irq_pending !== 4'b0001) begin bad++; $display("FAIL stall_capture: got %b exp %b", bus.irq_pending, 4'b0001); end
    bus.stall = 1'b0; bus.exc_req = 1'b0;
    tick();
    total++; if (bus.pc !== irq_vec(0) || bus.cause !== 8'h80) begin bad++; $display("FAIL stall_irq: pc %h cause %h exp %h 80", bus.pc, bus.cause, irq_vec(0)); end
    total++; if (bus.epc !== 32'h400 || bus.trap_taken !== 1'b1) begin bad++; $display("FAIL stall_irq_epc: epc %h trap %b exp 00000400 1", bus.epc, bus.trap_taken); end
  endtask

  task automatic test_ack_set_race();
    bus.pc_next_in = 32'h8000_0020; bus.irq = 4'b0000;
    tick();
    bus.irq = 4'b0001; bus.irq_ack = 1'b1; bus.ack_id = 2'd0;
    tick();
    total++; if (bus.irq_pending !== 4'b0001) begin bad++; $display("FAIL race_set_wins: got %b exp %b", bus.irq_pending, 4'b0001); end
    tick();
    bus.irq_ack = 1'b0;
    total++; if (bus.irq_pending !== 4'b0000) begin bad++; $display("FAIL race_ack_later: got %b exp %b", bus.irq_pending, 4'b0000); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_irq_basic();
    test_mask_ack();
    test_exception_priority();
    test_kernel_violation();
    test_illegal_eret();
    test_stall();
    test_ack_set_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
